// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    FS_BOOT   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2,
    FS_FAULT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// Two-entry FIFO of {pc, inst} absorbing responses while the decoder stalls.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t [1:0] mem;
  logic rd_ptr, wr_ptr;

  assign head = mem[rd_ptr];

  // Caller guarantees push into a full buffer only alongside a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency imem reads, buffers
// responses across decoder stalls and squashes wrong-path work on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  output logic        fetch_fault
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, resp_pc;
  logic         epoch, resp_epoch, resp_pending;
  logic [1:0]   skid_count;
  fetch_entry_t skid_head;
  logic         in_run, do_halt, do_redir, redir_bad, flush, live;
  logic         skid_push, skid_pop;

  assign in_run    = (state == FS_RUN);
  assign do_halt   = in_run & halt;
  assign do_redir  = in_run & redirect & ~halt;
  assign redir_bad = do_redir & (|redirect_pc[1:0]);
  assign flush     = do_halt | do_redir;
  // Responses from before the last redirect carry a stale epoch.
  assign live      = in_run & resp_pending & (resp_epoch == epoch);
  assign skid_pop  = in_run & ~flush & ~stall & (skid_count != 2'd0);
  assign skid_push = live & ~flush & (stall | (skid_count != 2'd0));

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (flush),
    .din   ('{pc: resp_pc, inst: imem_rdata}),
    .count (skid_count),
    .head  (skid_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FS_BOOT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_BOOT: state_nxt = FS_RUN;
      FS_RUN: begin
        if (halt)           state_nxt = FS_HALTED;
        else if (redir_bad) state_nxt = FS_FAULT;
      end
      default: state_nxt = state;
    endcase
  end

  // Credit check: buffered + in-flight never exceeds skid depth.
  always_comb begin
    imem_req = 1'b0;
    if (in_run && (({1'b0, skid_count} + {2'b00, resp_pending}) < 3'd2))
      imem_req = 1'b1;
  end

  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= RESET_PC;
      epoch        <= 1'b0;
      resp_pending <= 1'b0;
      resp_pc      <= '0;
      resp_epoch   <= 1'b0;
      inst         <= INST_NOP;
      pc           <= '0;
      inst_valid   <= 1'b0;
      fetch_fault  <= 1'b0;
    end else begin
      if (do_redir && !redir_bad) fetch_pc <= redirect_pc;
      else if (imem_req)          fetch_pc <= fetch_pc + PC_STEP;

      if (do_redir) epoch <= ~epoch;
      if (redir_bad) fetch_fault <= 1'b1;

      resp_pending <= imem_req & ~do_halt;
      if (imem_req) begin
        resp_pc    <= fetch_pc;
        resp_epoch <= epoch;
      end

      if (flush) begin
        inst_valid <= 1'b0;
      end else if (in_run && !stall) begin
        if (skid_count != 2'd0) begin
          inst       <= skid_head.inst;
          pc         <= skid_head.pc;
          inst_valid <= 1'b1;
        end else if (live) begin
          inst       <= imem_rdata;
          pc         <= resp_pc;
          inst_valid <= 1'b1;
        end else begin
          inst_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus async-reset and halt sequences.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hDEAD_0000;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic [31:0] inst, pc;
  logic        inst_valid, fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        req;
    logic [31:0] addr;
    logic        chk_addr;
    logic        valid;
    logic [31:0] pc;
    logic        fault;
  } vec_t;

  vec_t vt [25];

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .inst        (inst),
    .pc          (pc),
    .inst_valid  (inst_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory: word at addr is addr ^ KEY, returned one cycle after the request.
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ KEY;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic h, input logic q, input logic [31:0] a,
                              input logic ca, input logic v, input logic [31:0] p,
                              input logic f);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rp; t.halt = h; t.req = q;
    t.addr = a; t.chk_addr = ca; t.valid = v; t.pc = p; t.fault = f;
    return t;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk32({tag, " inst"}, inst, 32'h0000_0013);
    chk32({tag, " pc"}, pc, 32'h0);
    chk1({tag, " valid"}, inst_valid, 1'b0);
    chk1({tag, " req"}, imem_req, 1'b0);
    chk1({tag, " fault"}, fetch_fault, 1'b0);
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      stall = vt[i].stall; redirect = vt[i].redir;
      redirect_pc = vt[i].rpc; halt = vt[i].halt;
      @(posedge clk);
      @(negedge clk);
      chk1($sformatf("row%0d req", i), imem_req, vt[i].req);
      if (vt[i].chk_addr) chk32($sformatf("row%0d addr", i), imem_addr, vt[i].addr);
      chk1($sformatf("row%0d valid", i), inst_valid, vt[i].valid);
      chk32($sformatf("row%0d pc", i), pc, vt[i].pc);
      if (vt[i].valid) chk32($sformatf("row%0d inst", i), inst, vt[i].pc ^ KEY);
      chk1($sformatf("row%0d fault", i), fetch_fault, vt[i].fault);
    end
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
  endtask

  initial begin
    //             stall redir rpc           halt req addr          ca valid pc            fault
    vt[0]  = mk(O, O, 32'h0,   O, I, 32'h000, I, O, 32'h000, O);
    vt[1]  = mk(O, O, 32'h0,   O, I, 32'h004, I, O, 32'h000, O);
    vt[2]  = mk(O, O, 32'h0,   O, I, 32'h008, I, I, 32'h000, O);
    vt[3]  = mk(O, O, 32'h0,   O, I, 32'h00C, I, I, 32'h004, O);
    vt[4]  = mk(O, O, 32'h0,   O, I, 32'h010, I, I, 32'h008, O);
    vt[5]  = mk(I, O, 32'h0,   O, O, 32'h014, I, I, 32'h008, O);
    vt[6]  = mk(I, O, 32'h0,   O, O, 32'h014, I, I, 32'h008, O);
    vt[7]  = mk(I, O, 32'h0,   O, O, 32'h014, I, I, 32'h008, O);
    vt[8]  = mk(O, O, 32'h0,   O, I, 32'h014, I, I, 32'h00C, O);
    vt[9]  = mk(O, O, 32'h0,   O, I, 32'h018, I, I, 32'h010, O);
    vt[10] = mk(O, O, 32'h0,   O, I, 32'h01C, I, I, 32'h014, O);
    vt[11] = mk(O, O, 32'h0,   O, I, 32'h020, I, I, 32'h018, O);
    vt[12] = mk(I, O, 32'h0,   O, O, 32'h024, I, I, 32'h018, O);
    vt[13] = mk(I, O, 32'h0,   O, O, 32'h024, I, I, 32'h018, O);
    vt[14] = mk(I, I, 32'h100, O, I, 32'h100, I, O, 32'h018, O);
    vt[15] = mk(O, O, 32'h0,   O, I, 32'h104, I, O, 32'h018, O);
    vt[16] = mk(O, O, 32'h0,   O, I, 32'h108, I, I, 32'h100, O);
    vt[17] = mk(O, O, 32'h0,   O, I, 32'h10C, I, I, 32'h104, O);
    vt[18] = mk(O, I, 32'h200, O, I, 32'h200, I, O, 32'h104, O);
    vt[19] = mk(O, O, 32'h0,   O, I, 32'h204, I, O, 32'h104, O);
    vt[20] = mk(O, O, 32'h0,   O, I, 32'h208, I, I, 32'h200, O);
    vt[21] = mk(O, O, 32'h0,   O, I, 32'h20C, I, I, 32'h204, O);
    vt[22] = mk(O, I, 32'h302, O, O, 32'h0,   O, O, 32'h204, I);
    vt[23] = mk(O, I, 32'h200, O, O, 32'h0,   O, O, 32'h204, I);
    vt[24] = mk(O, O, 32'h0,   O, O, 32'h0,   O, O, 32'h204, I);

    rst = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    apply_rows(0, 24);

    // Refill the skid, then pull reset mid-cycle and check it lands before the next edge.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    apply_rows(0, 6);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst = 1'b1;
    apply_rows(0, 4);

    // Halt and redirect together: halt wins, redirect target never requested.
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
    @(posedge clk);
    @(negedge clk);
    halt = 1'b0;
    chk1("halt req", imem_req, 1'b0);
    chk1("halt valid", inst_valid, 1'b0);
    chk1("halt fault", fetch_fault, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk1($sformatf("halted%0d req", k), imem_req, 1'b0);
      chk1($sformatf("halted%0d valid", k), inst_valid, 1'b0);
      chk1($sformatf("halted%0d addr400", k), imem_addr == 32'h400, 1'b0);
    end
    redirect = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
